// File: rtl/baseline_mac.sv
// baseline_mac: signed dot product, radix-8 Booth partial products reduced by a carry-save tree.
// Redundant (sum, carry) output; latency 1, or 2 with BASELINE_IN_REG_EN; new vector every cycle, no stall.
module baseline_mac #(
  parameter  int IN_SIZE_0    = 4,
  parameter  int IN_SIZE_1    = 8,
  parameter  int ARRAY_SIZE   = 8,
  localparam int PP_PER_MUL   = (IN_SIZE_1 + 2) / 3,
  localparam int PP_PER_ARRAY = PP_PER_MUL * ARRAY_SIZE,
  localparam int PP_SIZE      = IN_SIZE_0 + IN_SIZE_1,
  localparam int OUT_SIZE     = PP_SIZE + 2 * ($clog2(PP_PER_ARRAY) - 1)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [ARRAY_SIZE-1:0][IN_SIZE_0-1:0] in_0_i,
  input  logic [ARRAY_SIZE-1:0][IN_SIZE_1-1:0] in_1_i,
  output logic [1:0][OUT_SIZE-1:0]             out_o
);

  function automatic int rows_at(input int lvl);
    int n = PP_PER_ARRAY;
    for (int k = 0; k < lvl; k++) n = n - n / 3;
    return n;
  endfunction

  function automatic int tree_levels();
    int n = PP_PER_ARRAY;
    int l = 0;
    while (n > 2) begin
      n = n - n / 3;
      l++;
    end
    return l;
  endfunction

  localparam int LEVELS = tree_levels();
  // Multiples up to 4A of a signed A need three extra bits.
  localparam int MW     = IN_SIZE_0 + 3;
  localparam int BEXT   = 3 * PP_PER_MUL + 1;

  logic [ARRAY_SIZE-1:0][IN_SIZE_0-1:0] a_q;
  logic [ARRAY_SIZE-1:0][IN_SIZE_1-1:0] b_q;
  logic [OUT_SIZE-1:0]                  tree [LEVELS+1][PP_PER_ARRAY];

`ifdef BASELINE_IN_REG_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= in_0_i;
      b_q <= in_1_i;
    end
  end
`else
  assign a_q = in_0_i;
  assign b_q = in_1_i;
`endif

  for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
    logic signed [MW-1:0] a_x;
    logic signed [MW-1:0] a_3x;
    logic [BEXT-1:0]      b_x;

    assign a_x  = MW'($signed(a_q[i]));
    assign a_3x = a_x + (a_x <<< 1);
    // B sign-extended to whole digits with an implicit zero below the LSB.
    assign b_x  = {(BEXT-1)'($signed(b_q[i])), 1'b0};

    for (genvar j = 0; j < PP_PER_MUL; j++) begin : g_pp
      logic [3:0]           win;
      logic [2:0]           code;
      logic signed [MW-1:0] mult;
      logic signed [MW-1:0] prod;

      assign win  = b_x[3*j+3 -: 4];
      // Inverting a negative window yields the window of its magnitude.
      assign code = win[3] ? ~win[2:0] : win[2:0];

      always_comb begin
        case (code)
          3'd0:       mult = '0;
          3'd1, 3'd2: mult = a_x;
          3'd3, 3'd4: mult = a_x <<< 1;
          3'd5, 3'd6: mult = a_3x;
          default:    mult = a_x <<< 2;
        endcase
      end

      assign prod = win[3] ? -mult : mult;
      assign tree[0][i*PP_PER_MUL+j] = OUT_SIZE'(prod) << (3 * j);
    end
  end

  // Each level folds groups of three rows into sum and carry; leftovers pass through.
  for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
    localparam int NP = rows_at(l - 1);
    localparam int G  = NP / 3;
    localparam int N  = NP - G;

    for (genvar g = 0; g < G; g++) begin : g_csa
      logic [OUT_SIZE-1:0] x, y, z;
      assign x = tree[l-1][3*g];
      assign y = tree[l-1][3*g+1];
      assign z = tree[l-1][3*g+2];
      assign tree[l][2*g]   = x ^ y ^ z;
      assign tree[l][2*g+1] = ((x & y) | (x & z) | (y & z)) << 1;
    end

    for (genvar r = 3 * G; r < NP; r++) begin : g_pass
      assign tree[l][2*G+r-3*G] = tree[l-1][r];
    end

    for (genvar r = N; r < PP_PER_ARRAY; r++) begin : g_idle
      assign tree[l][r] = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_o <= '0;
    end else begin
      out_o[0] <= tree[LEVELS][0];
      out_o[1] <= tree[LEVELS][1];
    end
  end

endmodule

// File: tb/tb_baseline_mac.sv
// Directed and random checks of the baseline_mac redundant dot-product output.
module tb_baseline_mac;

  localparam int IN_SIZE_0  = 4;
  localparam int IN_SIZE_1  = 8;
  localparam int ARRAY_SIZE = 8;
  localparam int OUT_SIZE   = 20;
`ifdef BASELINE_IN_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [ARRAY_SIZE-1:0][IN_SIZE_0-1:0] in_0 = '0;
  logic [ARRAY_SIZE-1:0][IN_SIZE_1-1:0] in_1 = '0;
  logic [1:0][OUT_SIZE-1:0]             out;

  int errors = 0;
  int checks = 0;
  int hist[$];

  baseline_mac dut (
    .clk_i (clk),
    .rst_i (rst),
    .in_0_i(in_0),
    .in_1_i(in_1),
    .out_o (out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int got_sum();
    logic signed [OUT_SIZE:0] s0, s1;
    s0 = signed'({out[0][OUT_SIZE-1], out[0]});
    s1 = signed'({out[1][OUT_SIZE-1], out[1]});
    return int'(s0 + s1);
  endfunction

  function automatic int model();
    int acc = 0;
    int av, bv;
    for (int i = 0; i < ARRAY_SIZE; i++) begin
      av = $signed(in_0[i]);
      bv = $signed(in_1[i]);
      acc += av * bv;
    end
    return acc;
  endfunction

  task automatic rand_vec(input int k);
    in_0 = $urandom();
    in_1 = {$urandom(), $urandom()};
    if (k % 10 == 3) begin
      for (int i = 0; i < ARRAY_SIZE; i++) begin
        in_0[i] = 4'h8;
        in_1[i] = 8'h80;
      end
    end
  endtask

  task automatic test_reset();
    in_0 = '0;
    in_1 = '0;
    rst  = 1'b1;
    repeat (5) begin
      tick();
      checks++;
      if (out !== '0) begin
        errors++;
        $display("FAIL reset_hold out0=%h out1=%h expected 0", out[0], out[1]);
      end
    end
    rst = 1'b0;
    repeat (3) begin
      tick();
      checks++;
      if (got_sum() !== 0) begin
        errors++;
        $display("FAIL reset_release_zero sum=%0d expected 0", got_sum());
      end
    end
  endtask

  task automatic test_corners();
    logic [3:0] ca [5] = '{4'h7, 4'h8, 4'h7, 4'h8, 4'h0};
    logic [7:0] cb [5] = '{8'h7F, 8'h80, 8'h80, 8'h7F, 8'h00};
    int         ce [5] = '{7112, 8192, -7168, -8128, 0};
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < ARRAY_SIZE; i++) begin
        in_0[i] = ca[k];
        in_1[i] = cb[k];
      end
      repeat (LAT) tick();
      checks++;
      if (got_sum() !== ce[k]) begin
        errors++;
        $display("FAIL corner_%0d sum=%0d expected %0d", k, got_sum(), ce[k]);
      end
    end
  endtask

  task automatic test_lanes();
    int va [ARRAY_SIZE] = '{1, 2, 3, 4, 5, 6, 7, -8};
    int vb [ARRAY_SIZE] = '{1, -1, 2, -2, 3, -3, 100, -100};
    for (int i = 0; i < ARRAY_SIZE; i++) begin
      in_0[i] = 4'(va[i]);
      in_1[i] = 8'(vb[i]);
    end
    repeat (LAT) tick();
    checks++;
    if (got_sum() !== 1494) begin
      errors++;
      $display("FAIL mixed_lanes sum=%0d expected 1494", got_sum());
    end
    in_0 = '0;
    in_1 = '0;
    in_0[3] = 4'hF;
    in_1[3] = 8'hFF;
    repeat (LAT) tick();
    checks++;
    if (got_sum() !== 1) begin
      errors++;
      $display("FAIL single_lane sum=%0d expected 1", got_sum());
    end
  endtask

  task automatic test_random();
    hist.delete();
    for (int k = 0; k < 100; k++) begin
      rand_vec(k);
      repeat (4) begin
        hist.push_back(model());
        tick();
        if (hist.size() == LAT) begin
          int exp_v = hist.pop_front();
          checks++;
          if (got_sum() !== exp_v) begin
            errors++;
            $display("FAIL random_%0d sum=%0d expected %0d", k, got_sum(), exp_v);
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    hist.delete();
    for (int k = 0; k < 50; k++) begin
      rand_vec(k);
      hist.push_back(model());
      tick();
      if (hist.size() == LAT) begin
        int exp_v = hist.pop_front();
        checks++;
        if (got_sum() !== exp_v) begin
          errors++;
          $display("FAIL burst_%0d sum=%0d expected %0d", k, got_sum(), exp_v);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    hist.delete();
    for (int k = 0; k < 8; k++) begin
      rand_vec(k + 1);
      hist.push_back(model());
      tick();
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out !== '0) begin
      errors++;
      $display("FAIL async_reset_immediate out0=%h out1=%h expected 0", out[0], out[1]);
    end
    hist.delete();
    for (int k = 0; k < 2; k++) begin
      rand_vec(k);
      tick();
      checks++;
      if (out !== '0) begin
        errors++;
        $display("FAIL async_reset_hold out0=%h out1=%h expected 0", out[0], out[1]);
      end
    end
    #3;
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      rand_vec(k);
      hist.push_back(model());
      tick();
      if (hist.size() == LAT) begin
        int exp_v = hist.pop_front();
        checks++;
        if (got_sum() !== exp_v) begin
          errors++;
          $display("FAIL post_reset_%0d sum=%0d expected %0d", k, got_sum(), exp_v);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_corners();
    test_lanes();
    test_random();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
